// File: rtl/anc_pkg.sv
// anc_pkg: shared types for the ANC sample feeder
package anc_pkg;
  localparam int ANC_DATA_W = 12;
  typedef struct packed {
    logic signed [ANC_DATA_W-1:0] main_I;
    logic signed [ANC_DATA_W-1:0] main_Q;
    logic signed [ANC_DATA_W-1:0] noise_I;
    logic signed [ANC_DATA_W-1:0] noise_Q;
  } anc_sample_t;
  typedef enum logic {FEED_IDLE, FEED_RUN} feed_state_t;
endpackage

// File: rtl/anc_sync_fifo.sv
// anc_sync_fifo: single-clock FIFO with occupancy count; full refuses push even on a same-cycle pop
module anc_sync_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end
  always_ff @(posedge clock) if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/anc_sample_feeder.sv
// anc_sample_feeder: buffers upstream samples and paces them onto the canceller buses,
// one sigEnable strobe per ENABLE_PERIOD slot once PREFILL samples are buffered
module anc_sample_feeder
  import anc_pkg::*;
#(
  parameter int DATA_BUS_SIZE = 12,
  parameter int FIFO_DEPTH = 8,
  parameter int ENABLE_PERIOD = 2,
  parameter int PREFILL = 1,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic signed [DATA_BUS_SIZE-1:0] in_main_I,
  input  logic signed [DATA_BUS_SIZE-1:0] in_main_Q,
  input  logic signed [DATA_BUS_SIZE-1:0] in_noise_I,
  input  logic signed [DATA_BUS_SIZE-1:0] in_noise_Q,
  output logic                            sigEnable,
  output logic signed [DATA_BUS_SIZE-1:0] signalChannel_I,
  output logic signed [DATA_BUS_SIZE-1:0] signalChannel_Q,
  output logic signed [DATA_BUS_SIZE-1:0] noiseChannel_I,
  output logic signed [DATA_BUS_SIZE-1:0] noiseChannel_Q,
  output logic [LW-1:0]                   fifo_level,
  output logic [15:0]                     underrun_count
);
  localparam int W = 4 * DATA_BUS_SIZE;
  localparam int PW = $clog2(ENABLE_PERIOD);
  feed_state_t state, state_d;
  logic [PW-1:0] phase, phase_d;
  logic slot, pop, full, empty;
  logic [W-1:0] head;
  assign in_ready = !full;
  anc_sync_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) fifo (
    .clock (clock),
    .reset (reset),
    .push  (in_valid),
    .pop   (pop),
    .din   ({in_main_I, in_main_Q, in_noise_I, in_noise_Q}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );
  // Underrun never drops back to IDLE; only reset re-arms the prefill wait.
  always_comb begin
    state_d = (state == FEED_IDLE && fifo_level >= LW'(PREFILL)) ? FEED_RUN : state;
    slot = state == FEED_RUN && phase == PW'(ENABLE_PERIOD - 1);
    phase_d = (state == FEED_RUN && !slot) ? phase + PW'(1) : '0;
    pop = slot && !empty;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FEED_IDLE;
      phase <= '0;
    end else begin
      state <= state_d;
      phase <= phase_d;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      sigEnable <= 1'b0;
      {signalChannel_I, signalChannel_Q, noiseChannel_I, noiseChannel_Q} <= '0;
      underrun_count <= '0;
    end else begin
      sigEnable <= pop;
      if (pop) {signalChannel_I, signalChannel_Q, noiseChannel_I, noiseChannel_Q} <= head;
      if (slot && empty && underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_anc_sample_feeder.sv
// tb_anc_sample_feeder: three feeder configurations driven by randomized upstream traffic,
// checked against a queue-based reference model through a strobe-driven scoreboard
module tb_anc_sample_feeder;
  import anc_pkg::*;
  localparam int EPS [3] = '{2, 4, 2};
  localparam int PFS [3] = '{1, 1, 4};
  logic clk, rst;
  logic vld [3];
  anc_sample_t din [3];
  logic rdy [3], se [3];
  logic signed [11:0] so_i [3], so_q [3], no_i [3], no_q [3];
  logic [3:0] lvl [3];
  logic [15:0] ur [3];
  int mode;
  int vecs, errs;
  anc_sample_t dir [3];
  int di [3];
  longint base [3];
  anc_sample_t fq [3][$];
  anc_sample_t exp_q [3][$];
  bit run [3], took [3], exp_se [3];
  int cyc_in_run [3], n_ur [3];
  bit rst_hit;
  int m_lv;
  bit m_slot;
  anc_sample_t held [3];
  logic [63:0] r64;

  for (genvar g = 0; g < 3; g++) begin : cfg
    anc_sample_feeder #(
      .DATA_BUS_SIZE (12),
      .FIFO_DEPTH    (8),
      .ENABLE_PERIOD (EPS[g]),
      .PREFILL       (PFS[g])
    ) dut (
      .clock           (clk),
      .reset           (rst),
      .in_valid        (vld[g]),
      .in_ready        (rdy[g]),
      .in_main_I       (din[g].main_I),
      .in_main_Q       (din[g].main_Q),
      .in_noise_I      (din[g].noise_I),
      .in_noise_Q      (din[g].noise_Q),
      .sigEnable       (se[g]),
      .signalChannel_I (so_i[g]),
      .signalChannel_Q (so_q[g]),
      .noiseChannel_I  (no_i[g]),
      .noiseChannel_Q  (no_q[g]),
      .fifo_level      (lvl[g]),
      .underrun_count  (ur[g])
    );
  end

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Reference model: a sample queue plus a count of cycles spent running;
  // every ENABLE_PERIOD-th running cycle is a delivery slot.
  always @(posedge clk) begin
    rst_hit = rst;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        fq[k].delete();
        exp_q[k].delete();
        run[k] = 0;
        cyc_in_run[k] = 0;
        n_ur[k] = 0;
        took[k] = 0;
        exp_se[k] = 0;
      end else begin
        m_lv = fq[k].size();
        m_slot = run[k] && (cyc_in_run[k] % EPS[k] == EPS[k] - 1);
        took[k] = vld[k] && m_lv < 8;
        exp_se[k] = m_slot && m_lv > 0;
        if (exp_se[k]) exp_q[k].push_back(fq[k].pop_front());
        else if (m_slot) n_ur[k]++;
        if (took[k]) fq[k].push_back(din[k]);
        if (run[k]) cyc_in_run[k]++;
        else if (m_lv >= PFS[k]) run[k] = 1;
      end
    end
  end

  task automatic chk(input string nm, input int k, input longint act, input longint exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s cfg%0d @%0t: got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      longint ue;
      if (rst_hit) held[k] = '0;
      chk("sigEnable", k, se[k], exp_se[k]);
      if (se[k]) begin
        chk("strobe_has_expected", k, exp_q[k].size(), 1);
        if (exp_q[k].size() > 0) held[k] = exp_q[k].pop_front();
      end
      chk("channel_bus", k, {so_i[k], so_q[k], no_i[k], no_q[k]}, held[k]);
      chk("in_ready", k, rdy[k], fq[k].size() < 8);
      chk("fifo_level", k, lvl[k], fq[k].size());
      ue = base[k] + n_ur[k];
      chk("underrun_count", k, ur[k], ue > 65535 ? 65535 : ue);
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      vld[k] = 0;
      din[k] = '0;
      di[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!vld[k] || took[k]) begin
          r64 = {$urandom, $urandom};
          din[k] = r64[47:0];
          if (mode == 0) begin
            vld[k] = di[k] < 3;
            if (di[k] < 3) din[k] = dir[di[k]];
            di[k]++;
          end else if (mode == 1) vld[k] = 1;
          else if (mode == 2) vld[k] = 0;
          else vld[k] = $urandom_range(2) != 0;
        end
      end
    end
  end

  task automatic cycles(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    rst = 1;
    mode = 0;
    base = '{0, 0, 0};
    dir[0] = '{12'sd100, -12'sd100, 12'sd50, -12'sd50};
    dir[1] = '{12'sd1, 12'sd2, 12'sd3, 12'sd4};
    dir[2] = '{12'h800, 12'h7FF, 12'h000, 12'hFFF};
    cycles(3);
    rst = 0;
    cycles(30);
    mode = 1;
    cycles(80);
    mode = 2;
    cycles(30);
    force cfg[0].dut.underrun_count = 16'hFFFE;
    base[0] = 65534 - n_ur[0];
    #1 release cfg[0].dut.underrun_count;
    cycles(30);
    mode = 3;
    cycles(150);
    rst = 1;
    cycles(1);
    rst = 0;
    base[0] = 0;
    cycles(150);
    mode = 1;
    cycles(40);
    mode = 2;
    cycles(40);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
